// File: rtl/track_mixer.sv
// track_mixer: N-track playback mixer; one sample per enabled track per DAC LR frame, gain, saturating sum.
// Optional feature macro TRACK_MIXER_LOOP_EN: wrap the frame index at end of track instead of stopping.
module track_mixer #(
   parameter int NUM_TRACKS = 4,
   parameter int SAMPLE_W   = 16,
   parameter int GAIN_W     = 8,
   parameter int ADDR_W     = 20
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_AUD_DACLRCK,
   input  logic                         i_play,
   input  logic                         i_rewind,
   input  logic [NUM_TRACKS-1:0]        i_track_en,
   input  logic [NUM_TRACKS*ADDR_W-1:0] i_track_base,
   input  logic [ADDR_W-1:0]            i_track_len,
   input  logic [NUM_TRACKS*GAIN_W-1:0] i_gain,
   output logic                         o_mem_req,
   output logic [ADDR_W-1:0]            o_mem_addr,
   input  logic                         i_mem_ack,
   input  logic [SAMPLE_W-1:0]          i_mem_rdata,
   output logic [SAMPLE_W-1:0]          o_data,
   output logic                         o_valid,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_overrun
);

   localparam int KW     = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
   localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_TRACKS) + 1;
   localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
   localparam logic [KW-1:0] LAST_K = KW'(NUM_TRACKS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] SCALE = 3'd2;
   localparam logic [2:0] SAT   = 3'd3;
   localparam logic [2:0] OUT   = 3'd4;

   logic                       lrckMeta_q, lrckSync_q, lrckPrev_q;
   logic                       trig;
   logic [2:0]                 state_q, state_d;
   logic [KW-1:0]              k_q, k_d, loadK;
   logic                       loadTrack;
   logic                       en_q;
   logic [ADDR_W-1:0]          base_q;
   logic [GAIN_W-1:0]          gain_q;
   logic [SAMPLE_W-1:0]        rdata_q, rdata_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [ADDR_W-1:0]          idx_q, idx_d;
   logic [SAMPLE_W-1:0]        data_q, data_d;
   logic                       valid_q, valid_d;
   logic                       done_q, done_d;
   logic                       overrun_q, overrun_d;
   logic                       rewindPend_q, rewindPend_d;
   logic                       rewindNow;
   logic [ADDR_W-1:0]          lenEff;
   logic signed [PROD_W-1:0]   prod, scaled;
   logic [SAMPLE_W-1:0]        clamped;
   logic [ADDR_W-1:0]          baseArr [NUM_TRACKS];
   logic [GAIN_W-1:0]          gainArr [NUM_TRACKS];

   for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_unpack
      assign baseArr[t] = i_track_base[t*ADDR_W +: ADDR_W];
      assign gainArr[t] = i_gain[t*GAIN_W +: GAIN_W];
   end

   // LR clock is asynchronous to i_clk; two flops resynchronise it, a third finds the rising edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lrckMeta_q <= 1'b0;
         lrckSync_q <= 1'b0;
         lrckPrev_q <= 1'b0;
      end else begin
         lrckMeta_q <= i_AUD_DACLRCK;
         lrckSync_q <= lrckMeta_q;
         lrckPrev_q <= lrckSync_q;
      end
   end

   assign trig      = lrckSync_q & ~lrckPrev_q;
   assign rewindNow = i_rewind | rewindPend_q;
   assign lenEff    = (i_track_len == '0) ? ADDR_W'(1) : i_track_len;

   assign prod   = $signed({{(GAIN_W+1){rdata_q[SAMPLE_W-1]}}, rdata_q}) *
                   $signed({{(SAMPLE_W+1){1'b0}}, gain_q});
   assign scaled = prod >>> (GAIN_W - 1);

   always_comb begin
      if (acc_q > SAT_MAX)      clamped = {1'b0, {(SAMPLE_W-1){1'b1}}};
      else if (acc_q < SAT_MIN) clamped = {1'b1, {(SAMPLE_W-1){1'b0}}};
      else                      clamped = acc_q[SAMPLE_W-1:0];
   end

   // Track configuration is captured as each track's fetch begins, so inputs may change mid-frame.
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      rdata_d      = rdata_q;
      acc_d        = acc_q;
      idx_d        = idx_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      done_d       = done_q;
      overrun_d    = overrun_q;
      rewindPend_d = rewindPend_q;
      loadTrack    = 1'b0;
      loadK        = k_q;
      if (state_q != IDLE) begin
         if (trig)     overrun_d    = 1'b1;
         if (i_rewind) rewindPend_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (rewindNow) begin
               idx_d        = '0;
               done_d       = 1'b0;
               overrun_d    = 1'b0;
               rewindPend_d = 1'b0;
            end
            if (trig && i_play && (!done_q || rewindNow)) begin
               state_d   = FETCH;
               k_d       = '0;
               acc_d     = '0;
               loadTrack = 1'b1;
               loadK     = '0;
            end
         end
         FETCH: begin
            if (!en_q) begin
               if (k_q == LAST_K) begin
                  state_d = SAT;
               end else begin
                  k_d       = k_q + KW'(1);
                  loadTrack = 1'b1;
                  loadK     = k_q + KW'(1);
               end
            end else if (i_mem_ack) begin
               rdata_d = i_mem_rdata;
               state_d = SCALE;
            end
         end
         SCALE: begin
            acc_d = acc_q + ACC_W'(scaled);
            if (k_q == LAST_K) begin
               state_d = SAT;
            end else begin
               state_d   = FETCH;
               k_d       = k_q + KW'(1);
               loadTrack = 1'b1;
               loadK     = k_q + KW'(1);
            end
         end
         SAT: begin
            data_d  = clamped;
            valid_d = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            if (idx_q == lenEff - ADDR_W'(1)) begin
`ifdef TRACK_MIXER_LOOP_EN
               idx_d = '0;
`else
               done_d = 1'b1;
`endif
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         k_q          <= '0;
         rdata_q      <= '0;
         acc_q        <= '0;
         idx_q        <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
         rewindPend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         rdata_q      <= rdata_d;
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
         rewindPend_q <= rewindPend_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         en_q   <= 1'b0;
         base_q <= '0;
         gain_q <= '0;
      end else if (loadTrack) begin
         en_q   <= i_track_en[loadK];
         base_q <= baseArr[loadK];
         gain_q <= gainArr[loadK];
      end
   end

   // Request and address derive only from registers, so reset drops them without waiting for a clock.
   assign o_mem_req  = (state_q == FETCH) && en_q;
   assign o_mem_addr = base_q + idx_q;
   assign o_data     = data_q;
   assign o_valid    = valid_q;
   assign o_busy     = (state_q != IDLE);
   assign o_done     = done_q;
   assign o_overrun  = overrun_q;

endmodule
